sbox_iso_map_stage: RTL

Registered front-end stage of the composite-field AES S-box datapath. It takes an input byte and applies the isomorphic mapping δ from GF(2^8) to GF((2^4)^2). It then computes the 4-bit value d that the downstream GF(2^4) inverse stage consumes, and forwards the mapped nibbles ah/al alongside d. Flow control is valid/ready, so the stage can stall without losing data.

---
 rtl/sbox_iso_map_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/sbox_iso_map_stage.sv
// Composite-field AES S-box front end: isomorphic map delta plus the GF(2^4) inverse operand d, valid/ready registered.
// Define SBOX_MAP_PIPE_EN to split delta and the d computation into two registered stages.
`timescale 1ns/1ps
module sbox_iso_map_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_ah,
    output logic [3:0] out_al,
    output logic [3:0] out_d
);

    localparam logic [3:0] LAMBDA = 4'hC;

    function automatic logic [7:0] iso_map(input logic [7:0] q);
        logic [7:0] p;
        p[7] = q[7] ^ q[5];
        p[6] = q[7] ^ q[6] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
        p[5] = q[7] ^ q[5] ^ q[3] ^ q[2];
        p[4] = q[7] ^ q[5] ^ q[3] ^ q[2] ^ q[1];
        p[3] = q[7] ^ q[6] ^ q[2] ^ q[1];
        p[2] = q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
        p[1] = q[6] ^ q[4] ^ q[1];
        p[0] = q[6] ^ q[1] ^ q[0];
        return p;
    endfunction

    // Multiply by x modulo x^4+x+1
    function automatic logic [3:0] xtime4(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] a1, a2, a3;
        a1 = xtime4(a);
        a2 = xtime4(a1);
        a3 = xtime4(a2);
        return (b[0] ? a  : 4'h0) ^ (b[1] ? a1 : 4'h0)
             ^ (b[2] ? a2 : 4'h0) ^ (b[3] ? a3 : 4'h0);
    endfunction

    function automatic logic [3:0] calc_d(input logic [3:0] ah, input logic [3:0] al);
        return gf16_mul(LAMBDA, gf16_mul(ah, ah)) ^ gf16_mul(ah ^ al, al);
    endfunction

    logic [7:0] mapped;
    logic       in_fire;

    always_comb begin
        mapped = iso_map(in_data);
    end

    assign in_fire = in_valid && in_ready;

`ifdef SBOX_MAP_PIPE_EN
    logic       s1_valid;
    logic [3:0] s1_ah;
    logic [3:0] s1_al;
    logic       s1_adv;

    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ah    <= '0;
            s1_al    <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_ah    <= mapped[7:4];
            s1_al    <= mapped[3:0];
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ah    <= '0;
            out_al    <= '0;
            out_d     <= '0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            out_ah    <= s1_ah;
            out_al    <= s1_al;
            out_d     <= calc_d(s1_ah, s1_al);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ah    <= '0;
            out_al    <= '0;
            out_d     <= '0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_ah    <= mapped[7:4];
            out_al    <= mapped[3:0];
            out_d     <= calc_d(mapped[7:4], mapped[3:0]);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule
